vga_scan: RTL and testbench

- Raster timing generator and pixel output stage for the game display.
- Generates the 640x480@60 scan, drives row_addr/col_addr to the pixel sources (ground, dinosaur, obstacles), samples their combined 1-bit px, and emits hs/vs/RGB to the VGA connector.
- Also provides a pixel-rate enable and a once-per-frame tick for game-logic pacing.

---
 rtl/vga_scan_if.sv | 25 ++
 rtl/vga_scan.sv | 148 ++++++++++++++
 tb/tb_vga_scan.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
// Pixel-side bundle of the VGA scan generator: address out, pixel bit in, sync/colour out.
// The master modport is the scan generator; the slave modport is the pixel source / connector side.
interface vga_scan_if;
  logic       px;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic       pix_en;
  logic       hs;
  logic       vs;
  logic       rdn;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       frame_tick;

  modport master (
    input  px,
    output row_addr, col_addr, pix_en, hs, vs, rdn, r, g, b, frame_tick
  );

  modport slave (
    output px,
    input  row_addr, col_addr, pix_en, hs, vs, rdn, r, g, b, frame_tick
  );
endinterface

// File: rtl/vga_scan.sv
// Raster timing generator and two-stage pixel output pipeline for a 640x480@60 style scan.
// Optional VGA_BORDER_EN: forces FG_COLOR on the outermost visible rows/columns.
module vga_scan #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic       CLK,
  input  logic       N_rst,
  vga_scan_if.master vga
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [9:0] HVis     = 10'(H_VIS);
  localparam logic [9:0] HSyncBeg = 10'(H_VIS + H_FP);
  localparam logic [9:0] HSyncEnd = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] HLast    = 10'(H_TOT - 1);
  localparam logic [9:0] VVis     = 10'(V_VIS);
  localparam logic [9:0] VSyncBeg = 10'(V_VIS + V_FP);
  localparam logic [9:0] VSyncEnd = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] VLast    = 10'(V_TOT - 1);

`ifdef VGA_BORDER_EN
  localparam logic [9:0] ColLast = 10'(H_VIS - 1);
  localparam logic [8:0] RowLast = 9'(V_VIS - 1);
`endif

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan: CLK_DIV must be at least 1");
  end

  // Pixel-rate divider and raster counters
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            pix_en_q;
  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [9:0]      v_cnt_q, v_cnt_d;
  logic            h_last, v_last;

  // Stage 0: addresses and raw timing flags
  logic [9:0] col_q, col_d;
  logic [8:0] row_q, row_d;
  logic       vis0_q, vis0_d;
  logic       hs0_q, hs0_d;
  logic       vs0_q, vs0_d;

  // Stage 1: pins
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        rdn_q, rdn_d;
  logic [11:0] rgb_q, rgb_d;
  logic        px_on;

  always_comb begin
    div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;

    h_last  = (h_cnt_q == HLast);
    v_last  = (v_cnt_q == VLast);
    h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    col_d  = (h_cnt_q < HVis) ? h_cnt_q : 10'h3FF;
    row_d  = (v_cnt_q < VVis) ? v_cnt_q[8:0] : 9'h1FF;
    vis0_d = (h_cnt_q < HVis) && (v_cnt_q < VVis);
    hs0_d  = !((h_cnt_q >= HSyncBeg) && (h_cnt_q <= HSyncEnd));
    vs0_d  = !((v_cnt_q >= VSyncBeg) && (v_cnt_q <= VSyncEnd));
  end

  always_comb begin
    px_on = vga.px;
`ifdef VGA_BORDER_EN
    // Border is decided on the stage-0 address that px belongs to
    if ((col_q == 10'd0) || (col_q == ColLast) || (row_q == 9'd0) || (row_q == RowLast)) begin
      px_on = 1'b1;
    end
`endif
    hs_d  = hs0_q;
    vs_d  = vs0_q;
    rdn_d = !vis0_q;
    rgb_d = 12'h000;
    if (vis0_q) begin
      rgb_d = px_on ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge CLK or negedge N_rst) begin
    if (!N_rst) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      col_q     <= 10'd0;
      row_q     <= 9'd0;
      vis0_q    <= 1'b0;
      hs0_q     <= 1'b1;
      vs0_q     <= 1'b1;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rdn_q     <= 1'b1;
      rgb_q     <= 12'h000;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= (div_cnt_q == DivLast);
      if (pix_en_q) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        col_q   <= col_d;
        row_q   <= row_d;
        vis0_q  <= vis0_d;
        hs0_q   <= hs0_d;
        vs0_q   <= vs0_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        rdn_q   <= rdn_d;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign vga.row_addr   = row_q;
  assign vga.col_addr   = col_q;
  assign vga.pix_en     = pix_en_q;
  assign vga.hs         = hs_q;
  assign vga.vs         = vs_q;
  assign vga.rdn        = rdn_q;
  assign vga.r          = rgb_q[11:8];
  assign vga.g          = rgb_q[7:4];
  assign vga.b          = rgb_q[3:0];
  assign vga.frame_tick = pix_en_q && h_last && v_last;

endmodule

// File: tb/tb_vga_scan.sv
// Randomized bench for vga_scan on a shrunken raster, checked every CLK against a
// position-based model: pixel index -> (h,v) -> expected pins two pixel periods later.
module tb_vga_scan;
  localparam int DIV = 3;
  localparam int HV = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VV = 10, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int FR = HT * VT;
  localparam logic [11:0] FG = 12'hA5C;
  localparam logic [11:0] BG = 12'h312;

  logic CLK = 1'b0;
  logic N_rst = 1'b0;
  int   t = 0;
  int   n_total = 0;
  int   n_bad = 0;

  int   mode = 0;
  int   sc = 0, sr = 0;
  logic tbl [64];

  vga_scan_if vif ();
  vga_scan_if vif1 ();

  vga_scan #(
    .CLK_DIV(DIV), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .CLK  (CLK),
    .N_rst(N_rst),
    .vga  (vif)
  );

  vga_scan #(
    .CLK_DIV(1), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut_div1 (
    .CLK  (CLK),
    .N_rst(N_rst),
    .vga  (vif1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge N_rst) begin
    if (!N_rst) t <= 0;
    else        t <= t + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic px_fn(input int col, input int row);
    case (mode)
      0:       return tbl[(col * 31 + row * 17) % 64];
      1:       return 1'b1;
      2:       return (col == sc) && (row == sr);
      default: return 1'b0;
    endcase
  endfunction

  // Expected pins for raster position n (pixel index since the scan started)
  task automatic model_pins(input int n, output logic [9:0] col, output logic [8:0] row,
                            output logic hs, output logic vs, output logic rdn,
                            output logic [11:0] rgb);
    int  h, v;
    bit  vis;
    logic on;
    h   = n % HT;
    v   = (n / HT) % VT;
    vis = (h < HV) && (v < VV);
    col = (h < HV) ? 10'(h) : 10'h3FF;
    row = (v < VV) ? 9'(v) : 9'h1FF;
    hs  = !((h >= HV + HFP) && (h < HV + HFP + HSY));
    vs  = !((v >= VV + VFP) && (v < VV + VFP + VSY));
    rdn = !vis;
    on  = px_fn(h, v);
`ifdef VGA_BORDER_EN
    if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) on = 1'b1;
`endif
    rgb = !vis ? 12'h000 : (on ? FG : BG);
  endtask

  always @(negedge CLK) begin
    int          u;
    logic        ep;
    logic [9:0]  ecol, dcol;
    logic [8:0]  erow, drow;
    logic        ehs, evs, erdn, dhs, dvs, drdn;
    logic [11:0] ergb, drgb;
    ep = (t >= 1) && (t % DIV == 0);
    u  = (t >= 1) ? (t - 1) / DIV : 0;
    check("pix_en", vif.pix_en, ep);
    check("frame_tick", vif.frame_tick, ep && (u % FR == FR - 1));
    if (u >= 1) model_pins(u - 1, ecol, erow, dhs, dvs, drdn, drgb);
    else begin ecol = 10'd0; erow = 9'd0; end
    check("col_addr", vif.col_addr, ecol);
    check("row_addr", vif.row_addr, erow);
    if (u >= 2) model_pins(u - 2, dcol, drow, ehs, evs, erdn, ergb);
    else begin ehs = 1'b1; evs = 1'b1; erdn = 1'b1; ergb = 12'h000; end
    check("hs", vif.hs, ehs);
    check("vs", vif.vs, evs);
    check("rdn", vif.rdn, erdn);
    check("rgb", {vif.r, vif.g, vif.b}, ergb);
    check("pix_en_div1", vif1.pix_en, t >= 1);
    vif.px = px_fn(int'(vif.col_addr), int'(vif.row_addr));
  end

  task automatic check_reset_vals();
    check("rst_pix_en", vif.pix_en, 1'b0);
    check("rst_col", vif.col_addr, 10'd0);
    check("rst_row", vif.row_addr, 9'd0);
    check("rst_sync", {vif.hs, vif.vs, vif.rdn}, 3'b111);
    check("rst_rgb", {vif.r, vif.g, vif.b}, 12'h000);
    check("rst_tick", vif.frame_tick, 1'b0);
    check("rst_pix_en_div1", vif1.pix_en, 1'b0);
  endtask

  task automatic new_pattern(input int m);
    mode = m;
    sc   = $urandom_range(0, HV - 1);
    sr   = $urandom_range(0, VV - 1);
    for (int i = 0; i < 64; i++) tbl[i] = 1'($urandom);
  endtask

  initial begin
    vif.px  = 1'b0;
    vif1.px = 1'b0;
    new_pattern(0);
    repeat (3) @(negedge CLK);
    check_reset_vals();
    #2 N_rst = 1'b1;
    for (int seg = 0; seg < 7; seg++) begin
      int len;
      len = (seg == 0) ? 2 * FR * DIV + 500 : $urandom_range(300, 3000);
      repeat (len) @(negedge CLK);
      // Assert reset away from any clock edge; outputs must clear without a CLK
      #2 N_rst = 1'b0;
      #1 check_reset_vals();
      new_pattern((seg < 3) ? seg + 1 : $urandom_range(0, 3));
      repeat (2) @(negedge CLK);
      #2 N_rst = 1'b1;
    end
    repeat (FR * DIV + 20) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
